// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI receive shifter with word FIFO, frame-error pulse and sticky overflow
// Builds DATA_W-bit words from mosi while ss is low and queues them for a valid/ready consumer.
module spi_slave_rx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ss,
  input  logic                          mosi,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0]  sh_q;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               frame_err_q;
  logic               overflow_q;

  logic [DATA_W-1:0]  sh_d;
  logic               word_done;
  logic               pop;
  logic               push_ok;

  always_comb begin
    sh_d      = MSB_FIRST ? {sh_q[DATA_W-2:0], mosi} : {mosi, sh_q[DATA_W-1:1]};
    word_done = (state_q == SHIFT) && !ss && (bit_cnt_q == LAST_BIT);
    pop       = (level_q != '0) && rx_ready;
    // A full FIFO still takes the word when the consumer frees a slot on the same edge.
    push_ok   = word_done && ((level_q != FULL_LVL) || pop);
    level_d   = level_q;
    if (push_ok && !pop) level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ss) begin
            sh_q      <= sh_d;
            bit_cnt_q <= CNT_W'(1);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!ss) begin
            sh_q      <= sh_d;
            bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
          end else begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            frame_err_q <= (bit_cnt_q != '0);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (push_ok) begin
        mem_q[wr_ptr_q] <= sh_d;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;

      if (word_done && !push_ok) overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = (level_q != '0);
  assign busy      = (state_q == SHIFT);
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - scoreboard bench for spi_slave_rx (MSB-first and LSB-first instances)
module tb_spi_slave_rx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst = 1'b0, ss = 1'b1, mosi = 1'b0, rx_ready = 1'b0, clr_ovf = 1'b0;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, rx_valid2, busy, busy2, ferr, ferr2, ovf, ovf2;
  logic [2:0] level, level2;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .ss(ss), .mosi(mosi), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_err(ferr), .overflow(ovf), .clr_ovf(clr_ovf),
    .level(level));

  spi_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .ss(ss), .mosi(mosi), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready), .busy(busy2), .frame_err(ferr2), .overflow(ovf2), .clr_ovf(clr_ovf),
    .level(level2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Reference model: words live in exp_q (MSB-first view) from acceptance until popped.
  logic [7:0] exp_q[$];
  bit         bits_q[$];
  bit         ovf_m = 1'b0, ferr_m = 1'b0, busy_m = 1'b0;

  always @(posedge clk or negedge rst) begin
    logic [7:0] w;
    bit         drop;
    if (!rst) begin
      exp_q.delete();
      bits_q.delete();
      ovf_m  = 1'b0;
      ferr_m = 1'b0;
      busy_m = 1'b0;
    end else begin
      ferr_m = 1'b0;
      drop   = 1'b0;
      if (!ss) begin
        busy_m = 1'b1;
        bits_q.push_back(mosi);
        if (bits_q.size() == DW) begin
          w = 8'h00;
          for (int i = 0; i < DW; i++) if (bits_q[i]) w = w | 8'(1 << (DW - 1 - i));
          bits_q.delete();
          if (exp_q.size() < DEPTH) exp_q.push_back(w);
          else drop = 1'b1;
        end
      end else begin
        busy_m = 1'b0;
        ferr_m = (bits_q.size() != 0);
        bits_q.delete();
      end
      if (drop) ovf_m = 1'b1;
      else if (clr_ovf) ovf_m = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
    check("level", 32'(level), 32'(exp_q.size()));
    check("overflow", 32'(ovf), 32'(ovf_m));
    check("frame_err", 32'(ferr), 32'(ferr_m));
    check("busy", 32'(busy), 32'(busy_m));
    check("lsb_level", 32'(level2), 32'(exp_q.size()));
    check("lsb_overflow", 32'(ovf2), 32'(ovf_m));
    check("lsb_frame_err", 32'(ferr2), 32'(ferr_m));
    if (rst && rx_ready && exp_q.size() != 0) begin
      check("rx_data", 32'(rx_data), 32'(exp_q[0]));
      check("lsb_rx_data", 32'(rx_data2), 32'(rev8(exp_q[0])));
      void'(exp_q.pop_front());
    end
  end

  // 0: hold low, 1: hold high, 2: random, 3: driven by the main sequence
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rx_ready = 1'b0;
      1: rx_ready = 1'b1;
      2: rx_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic send_bits(input logic [7:0] w, input int n, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      ss   = 1'b0;
      mosi = w[7-i];
      if (rdy_last && i == n - 1) rx_ready = 1'b1;
      @(posedge clk); #1;
    end
    if (rdy_last) rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit rdy_last);
    send_bits(w, 8, rdy_last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ss   = 1'b1;
      mosi = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    rdy_mode = 1;
    idle(DEPTH + 2);
    rdy_mode = 0;
    idle(1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_level", 32'(level), 32'h0);
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;

    send_word(8'hA5, 1'b0);
    check("t1_data", 32'(rx_data), 32'hA5);
    check("t1_level", 32'(level), 32'h1);
    check("t1_lsb_data", 32'(rx_data2), 32'hA5);
    check("t1_frame_err", 32'(ferr), 32'h0);
    drain();

    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    check("t2_level", 32'(level), 32'h2);
    check("t2_busy_hi", 32'(busy), 32'h1);
    idle(1);
    check("t2_busy_lo", 32'(busy), 32'h0);
    drain();

    send_bits(8'hAB, 5, 1'b0);
    idle(1);
    check("t3_ferr_pulse", 32'(ferr), 32'h1);
    check("t3_level", 32'(level), 32'h0);
    idle(1);
    check("t3_ferr_clear", 32'(ferr), 32'h0);
    send_word(8'h81, 1'b0);
    check("t3_data", 32'(rx_data), 32'h81);
    drain();

    for (int i = 1; i <= 5; i++) send_word(8'(i), 1'b0);
    idle(1);
    check("t4_level", 32'(level), 32'h4);
    check("t4_overflow", 32'(ovf), 32'h1);
    drain();
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("t4_clr_ovf", 32'(ovf), 32'h0);

    rdy_mode = 3;
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(8'(8'h10 + i), 1'b0);
    send_word(8'h14, 1'b1);
    check("t5_level", 32'(level), 32'h4);
    check("t5_overflow", 32'(ovf), 32'h0);
    drain();

    send_word(8'h21, 1'b0);
    send_word(8'h22, 1'b0);
    send_bits(8'hF0, 4, 1'b0);
    #2;
    rst = 1'b0;
    ss  = 1'b1;
    #1;
    check("t6_valid", 32'(rx_valid), 32'h0);
    check("t6_level", 32'(level), 32'h0);
    check("t6_data", 32'(rx_data), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_ferr", 32'(ferr), 32'h0);
    check("t6_lsb_data", 32'(rx_data2), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_word(8'h5A, 1'b0);
    check("t6_data_5a", 32'(rx_data), 32'h5A);
    check("t6_lsb_5a", 32'(rx_data2), 32'h5A);
    drain();

    rdy_mode = 2;
    for (int it = 0; it < 300; it++) begin
      int r;
      if (it % 60 == 30) rdy_mode = 0;
      if (it % 60 == 45) rdy_mode = 2;
      r = $urandom_range(0, 9);
      if (r <= 5) send_word(8'($urandom), 1'b0);
      else if (r <= 7) begin
        send_bits(8'($urandom), $urandom_range(1, 7), 1'b0);
        idle($urandom_range(1, 2));
      end else if (r == 8) idle($urandom_range(1, 3));
      else begin
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
